// File: rtl/branch_predictor_btb_pkg.sv
// Shared types for the branch predictor.
//   BP_XLEN    : PC / data width used by the table entry layout
//   bp_cnt_e   : 2-bit direction counter encodings
//   bp_entry_t : one BTB entry (valid, is_jump, tag, target, cnt)
package branch_predictor_btb_pkg;

  localparam int BP_XLEN = 32;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bp_cnt_e;

  // The tag field is kept at full PC width and holds pc >> (IDX_W+2), so the
  // entry layout does not depend on the number of table entries. The upper
  // bits of a stored tag are always zero.
  typedef struct packed {
    logic               valid;
    logic               is_jump;
    logic [BP_XLEN-1:0] tag;
    logic [BP_XLEN-1:0] target;
    logic [1:0]         cnt;
  } bp_entry_t;

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// bp_sat_counter: next value of a 2-bit saturating direction counter.
//   cnt      in  2  current counter value
//   taken    in  1  resolved direction
//   cnt_next out 2  cnt+1 (stops at 11) if taken, cnt-1 (stops at 00) if not
module bp_sat_counter
  import branch_predictor_btb_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with 2-bit direction counters.
// IF looks up the fetch PC combinationally every cycle; EX reports resolved
// branches/jumps, which update the table and statistics on the clock edge.
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_pc                      fetch PC
//   pred_taken, pred_target    prediction for if_pc
//   ex_valid, ex_stall         EX instruction present / pipeline stalled
//   ex_is_branch, ex_is_jump   instruction class in EX
//   ex_pc, ex_taken, ex_target resolved outcome
//   ex_pred_taken/_target      prediction carried down from IF
//   mispredict, redirect_pc    flush request and correct next PC
//   bp_clear                   invalidate all entries on next edge
//   stat_branches/_mispred     saturating statistics counters
// XLEN must match BP_XLEN from the package (entry layout).
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int         XLEN     = BP_XLEN,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CNT_INIT = CNT_WT,
  parameter int         STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic              ex_is_branch,
  input  logic              ex_is_jump,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic              bp_clear,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_entry_t        entries  [ENTRIES];
  logic [1:0]       cnt_upd  [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [XLEN-1:0]  if_tag;
  bp_entry_t        if_ent;
  logic             if_hit;

  logic [IDX_W-1:0] ex_idx;
  logic [XLEN-1:0]  ex_tag;
  bp_entry_t        ex_ent;
  logic             ex_hit;
  logic             upd;

  // Lookup: reads the registered table only, so a same-cycle update to the
  // same index is not visible until the following cycle.
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc >> (IDX_W + 2);
  assign if_ent = entries[if_idx];
  assign if_hit = if_ent.valid && (if_ent.tag == if_tag);

  assign pred_taken  = if_hit && (if_ent.is_jump || if_ent.cnt[1]);
  assign pred_target = if_hit ? if_ent.target : (if_pc + XLEN'(4));

  // Gating with rst_n keeps mispredict low for the whole reset window, even
  // if EX inputs are still toggling.
  assign upd = rst_n && ex_valid && !ex_stall && (ex_is_branch || ex_is_jump);

  assign mispredict = upd && ((ex_taken != ex_pred_taken) ||
                              (ex_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = ex_taken ? ex_target : (ex_pc + XLEN'(4));

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc >> (IDX_W + 2);
  assign ex_ent = entries[ex_idx];
  assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    bp_entry_t ent_q;
    logic      sel;

    assign sel        = upd && (ex_idx == IDX_W'(i));
    assign entries[i] = ent_q;

    bp_sat_counter u_cnt (
      .cnt      (ent_q.cnt),
      .taken    (ex_taken),
      .cnt_next (cnt_upd[i])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ent_q     <= '0;
        ent_q.cnt <= CNT_INIT;
      end else if (!ex_stall) begin
        if (sel) begin
          if (ex_hit) begin
            ent_q.cnt <= cnt_upd[i];
            if (ex_taken) begin
              ent_q.target  <= ex_target;
              ent_q.is_jump <= ex_is_jump;
            end
          end else if (ex_taken) begin
            ent_q.valid   <= 1'b1;
            ent_q.is_jump <= ex_is_jump;
            ent_q.tag     <= ex_tag;
            ent_q.target  <= ex_target;
            ent_q.cnt     <= ex_is_jump ? CNT_ST : CNT_INIT;
          end
        end
        // Placed after the update so a simultaneous clear leaves the entry invalid.
        if (bp_clear) ent_q.valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (upd && (stat_branches != '1))
        stat_branches <= stat_branches + STAT_W'(1);
      if (mispredict && (stat_mispred != '1))
        stat_mispred <= stat_mispred + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jump;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_taken, ex_pred_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        bp_clear;
  logic [31:0] stat_branches, stat_mispred;

  branch_predictor_btb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .bp_clear       (bp_clear),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] ifpc;
    logic        v, st, br, jp;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        clr;
    logic        e_pt;
    logic [31:0] e_tgt;
    logic        e_mp;
    logic [31:0] e_rpc;
    logic [31:0] e_sb;
    logic [31:0] e_sm;
  } vec_t;

  typedef struct {
    int          id;
    logic        pt;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] rpc;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Resolving instruction in EX plus the expected observation for this cycle.
  function automatic vec_t ex_vec(logic rst, logic [31:0] ifpc, logic st, logic br, logic jp,
                                  logic [31:0] pc, logic tk, logic [31:0] tgt, logic ptk,
                                  logic [31:0] ptgt, logic clr, logic e_pt, logic [31:0] e_tgt,
                                  logic e_mp, logic [31:0] e_rpc, logic [31:0] e_sb,
                                  logic [31:0] e_sm);
    vec_t x;
    x.rst = rst; x.ifpc = ifpc; x.v = 1'b1; x.st = st; x.br = br; x.jp = jp;
    x.pc = pc; x.tk = tk; x.tgt = tgt; x.ptk = ptk; x.ptgt = ptgt; x.clr = clr;
    x.e_pt = e_pt; x.e_tgt = e_tgt; x.e_mp = e_mp; x.e_rpc = e_rpc;
    x.e_sb = e_sb; x.e_sm = e_sm;
    return x;
  endfunction

  // Lookup-only cycle: EX holds a bubble at pc 0, so redirect_pc is 4.
  function automatic vec_t idle(logic rst, logic [31:0] ifpc, logic e_pt, logic [31:0] e_tgt,
                                logic [31:0] e_sb, logic [31:0] e_sm);
    vec_t x;
    x = ex_vec(rst, ifpc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
               e_pt, e_tgt, 1'b0, 32'h4, e_sb, e_sm);
    x.v = 1'b0;
    return x;
  endfunction

  task automatic apply(input vec_t x, input int id);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = x.rst; if_pc = x.ifpc; ex_valid = x.v; ex_stall = x.st;
    ex_is_branch = x.br; ex_is_jump = x.jp; ex_pc = x.pc; ex_taken = x.tk;
    ex_target = x.tgt; ex_pred_taken = x.ptk; ex_pred_target = x.ptgt; bp_clear = x.clr;
    e.id = id; e.pt = x.e_pt; e.tgt = x.e_tgt; e.mp = x.e_mp; e.rpc = x.e_rpc;
    e.sb = x.e_sb; e.sm = x.e_sm;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are combinational, observed mid-cycle before the edge
  // that commits this cycle's update.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (pred_taken !== e.pt) begin
        n_miss++; $display("FAIL v%0d pred_taken got %0b want %0b", e.id, pred_taken, e.pt);
      end
      if (pred_target !== e.tgt) begin
        n_miss++; $display("FAIL v%0d pred_target got %h want %h", e.id, pred_target, e.tgt);
      end
      if (mispredict !== e.mp) begin
        n_miss++; $display("FAIL v%0d mispredict got %0b want %0b", e.id, mispredict, e.mp);
      end
      if (redirect_pc !== e.rpc) begin
        n_miss++; $display("FAIL v%0d redirect_pc got %h want %h", e.id, redirect_pc, e.rpc);
      end
      if (stat_branches !== e.sb) begin
        n_miss++; $display("FAIL v%0d stat_branches got %0d want %0d", e.id, stat_branches, e.sb);
      end
      if (stat_mispred !== e.sm) begin
        n_miss++; $display("FAIL v%0d stat_mispred got %0d want %0d", e.id, stat_mispred, e.sm);
      end
    end
  end

  initial begin
    rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_stall = 1'b0; ex_is_branch = 1'b0;
    ex_is_jump = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0;
    ex_pred_target = '0; bp_clear = 1'b0;
    repeat (2) @(posedge clk);

    // ENTRIES=16: index = pc[5:2], tag = pc>>6.
    // 1: reset state
    vecs.push_back(idle(1, 32'h24, 0, 32'h28, 0, 0));
    // 2-3: beq 0x28 taken -> allocate; next lookup hits
    vecs.push_back(ex_vec(1, 32'h28, 0, 1, 0, 32'h28, 1, 32'h30, 0, 32'h2C, 0, 0, 32'h2C, 1, 32'h30, 0, 0));
    vecs.push_back(idle(1, 32'h28, 1, 32'h30, 1, 1));
    // 4-5: beq 0x24 not taken on miss -> no allocate
    vecs.push_back(ex_vec(1, 32'h24, 0, 1, 0, 32'h24, 0, 32'h50, 0, 32'h28, 0, 0, 32'h28, 0, 32'h28, 1, 1));
    vecs.push_back(idle(1, 32'h24, 0, 32'h28, 2, 1));
    // 6-9: loop at 0x40 taken x4 (10 -> 11 -> 11 -> 11)
    vecs.push_back(ex_vec(1, 32'h40, 0, 1, 0, 32'h40, 1, 32'h40, 0, 32'h44, 0, 0, 32'h44, 1, 32'h40, 2, 1));
    vecs.push_back(ex_vec(1, 32'h40, 0, 1, 0, 32'h40, 1, 32'h40, 1, 32'h40, 0, 1, 32'h40, 0, 32'h40, 3, 2));
    vecs.push_back(ex_vec(1, 32'h40, 0, 1, 0, 32'h40, 1, 32'h40, 1, 32'h40, 0, 1, 32'h40, 0, 32'h40, 4, 2));
    vecs.push_back(ex_vec(1, 32'h40, 0, 1, 0, 32'h40, 1, 32'h40, 1, 32'h40, 0, 1, 32'h40, 0, 32'h40, 5, 2));
    // 10-11: not taken once -> cnt 10, still predicts taken
    vecs.push_back(ex_vec(1, 32'h40, 0, 1, 0, 32'h40, 0, 32'h40, 1, 32'h40, 0, 1, 32'h40, 1, 32'h44, 6, 2));
    vecs.push_back(idle(1, 32'h40, 1, 32'h40, 7, 3));
    // 12-14: alias 0x68 onto 0x28's entry (same-cycle lookup sees old entry)
    vecs.push_back(ex_vec(1, 32'h28, 0, 1, 0, 32'h68, 1, 32'h80, 0, 32'h6C, 0, 1, 32'h30, 1, 32'h80, 7, 3));
    vecs.push_back(idle(1, 32'h28, 0, 32'h2C, 8, 4));
    vecs.push_back(idle(1, 32'h68, 1, 32'h80, 8, 4));
    // 15-16: stalled resolving branch changes nothing
    vecs.push_back(ex_vec(1, 32'h68, 1, 1, 0, 32'h68, 0, 32'h80, 1, 32'h80, 0, 1, 32'h80, 0, 32'h6C, 8, 4));
    vecs.push_back(idle(1, 32'h68, 1, 32'h80, 8, 4));
    // 17-18: jal at 0x100 allocates over 0x40's entry
    vecs.push_back(ex_vec(1, 32'h68, 0, 0, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 1, 32'h80, 1, 32'h200, 8, 4));
    vecs.push_back(idle(1, 32'h100, 1, 32'h200, 9, 5));
    // 19: right direction, wrong target -> mispredict
    vecs.push_back(ex_vec(1, 32'h100, 0, 1, 0, 32'h28, 1, 32'h30, 1, 32'h34, 0, 1, 32'h200, 1, 32'h30, 9, 5));
    // 20-23: bp_clear with an allocating update -> table empty, stats still count
    vecs.push_back(ex_vec(1, 32'h28, 0, 1, 0, 32'h40, 1, 32'h48, 1, 32'h48, 1, 1, 32'h30, 0, 32'h48, 10, 6));
    vecs.push_back(idle(1, 32'h28, 0, 32'h2C, 11, 6));
    vecs.push_back(idle(1, 32'h40, 0, 32'h44, 11, 6));
    vecs.push_back(idle(1, 32'h100, 0, 32'h104, 11, 6));
    // 24: PC+4 wraps
    vecs.push_back(idle(1, 32'hFFFFFFFC, 0, 32'h0, 11, 6));
    // 25-26: re-allocate 0x28
    vecs.push_back(ex_vec(1, 32'h28, 0, 1, 0, 32'h28, 1, 32'h30, 0, 32'h2C, 0, 0, 32'h2C, 1, 32'h30, 11, 6));
    vecs.push_back(idle(1, 32'h28, 1, 32'h30, 12, 7));
    // 27: async reset mid-cycle, observed before any clock edge
    vecs.push_back(ex_vec(0, 32'h28, 0, 1, 0, 32'h28, 1, 32'h30, 0, 32'h2C, 0, 0, 32'h2C, 0, 32'h30, 0, 0));
    // 28: after release the entry is still gone
    vecs.push_back(idle(1, 32'h28, 0, 32'h2C, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_miss++;
        $display("FAIL drain timeout got %0d pending want 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
